// File: rtl/tmr_vote_monitor.sv
// Triple-modular-redundancy voter with per-replica mismatch tracking,
// sticky fault latching and degraded voting once replicas are faulty.
module tmr_vote_monitor #(
  parameter int WIDTH   = 8,
  parameter int THRESH  = 4,
  parameter int CNT_W   = 8,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic             err_clr,
  output logic [WIDTH-1:0] voted,
  output logic             fault_a,
  output logic             fault_b,
  output logic             fault_c,
  output logic [CNT_W-1:0] err_cnt_a,
  output logic [CNT_W-1:0] err_cnt_b,
  output logic [CNT_W-1:0] err_cnt_c,
  output logic             tmr_error
);

  localparam int RW = $clog2(THRESH + 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(THRESH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] maj;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] rep   [3];
  logic [RW-1:0]    run_q [3];
  logic [CNT_W-1:0] cnt_q [3];
  logic [2:0]       miss;
  logic [2:0]       fault_q;
  logic             err_d;

  assign rep[0] = in_a;
  assign rep[1] = in_b;
  assign rep[2] = in_c;

  assign maj = (in_a & in_b) | (in_b & in_c) | (in_a & in_c);

  // Bit 0/1/2 of fault_q is replica A/B/C.
  always_comb begin
    sel   = maj;
    err_d = 1'b0;
    unique case (fault_q)
      3'b000: begin
        sel   = maj;
        err_d = (miss[0] & miss[1]) | (miss[1] & miss[2])
              | (miss[0] & miss[2]);
      end
      3'b001: begin
        sel   = in_b;
        err_d = (in_b != in_c);
      end
      3'b010: begin
        sel   = in_a;
        err_d = (in_a != in_c);
      end
      3'b100: begin
        sel   = in_a;
        err_d = (in_a != in_b);
      end
      3'b011: begin
        sel   = in_c;
        err_d = 1'b1;
      end
      3'b101: begin
        sel   = in_b;
        err_d = 1'b1;
      end
      3'b110: begin
        sel   = in_a;
        err_d = 1'b1;
      end
      3'b111: begin
        sel   = in_a;
        err_d = 1'b1;
      end
    endcase
  end

  for (genvar i = 0; i < 3; i++) begin : g_rep
    assign miss[i] = (rep[i] != maj);

    always_ff @(posedge clk) begin
      if (!rst || err_clr) begin
        run_q[i]   <= '0;
        fault_q[i] <= 1'b0;
        cnt_q[i]   <= '0;
      end else begin
        // Run length freezes once the replica is declared faulty.
        if (!fault_q[i]) begin
          if (miss[i]) begin
            run_q[i] <= run_q[i] + RW'(1);
            if (run_q[i] == RUN_LAST) fault_q[i] <= 1'b1;
          end else begin
            run_q[i] <= '0;
          end
        end
        if (miss[i] && cnt_q[i] != CNT_MAX)
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) tmr_error <= 1'b0;
    else      tmr_error <= err_d;
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] voted_q;
    always_ff @(posedge clk) begin
      if (!rst) voted_q <= '0;
      else      voted_q <= sel;
    end
    assign voted = voted_q;
  end else begin : g_comb
    assign voted = sel;
  end

  assign fault_a   = fault_q[0];
  assign fault_b   = fault_q[1];
  assign fault_c   = fault_q[2];
  assign err_cnt_a = cnt_q[0];
  assign err_cnt_b = cnt_q[1];
  assign err_cnt_c = cnt_q[2];

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Directed bench for tmr_vote_monitor: registered 8-bit-counter instance
// plus a combinational-output instance with 4-bit saturating counters.
module tb_tmr_vote_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       err_clr;
  logic [7:0] in_a, in_b, in_c;

  logic [7:0] voted, voted4;
  logic       fa, fb, fc, fa4, fb4, fc4;
  logic [7:0] ca, cb, cc;
  logic [3:0] ca4, cb4, cc4;
  logic       terr, terr4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tmr_vote_monitor u_dut (
    .clk(clk), .rst(rst),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .err_clr(err_clr), .voted(voted),
    .fault_a(fa), .fault_b(fb), .fault_c(fc),
    .err_cnt_a(ca), .err_cnt_b(cb), .err_cnt_c(cc),
    .tmr_error(terr)
  );

  tmr_vote_monitor #(.CNT_W(4), .REG_OUT(1'b0)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .err_clr(err_clr), .voted(voted4),
    .fault_a(fa4), .fault_b(fb4), .fault_c(fc4),
    .err_cnt_a(ca4), .err_cnt_b(cb4), .err_cnt_c(cc4),
    .tmr_error(terr4)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic clr,
                      input logic r);
    in_a    = a;
    in_b    = b;
    in_c    = c;
    err_clr = clr;
    rst     = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_clear(input string tag);
    chk({tag, "_faults"}, {fa, fb, fc}, 3'b000);
    chk({tag, "_cnt_a"}, ca, 0);
    chk({tag, "_cnt_b"}, cb, 0);
    chk({tag, "_cnt_c"}, cc, 0);
    chk({tag, "_faults4"}, {fa4, fb4, fc4}, 3'b000);
    chk({tag, "_cnt4"}, {ca4, cb4, cc4}, 12'h000);
  endtask

  initial begin
    step(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    step(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("rst_voted", voted, 8'h00);
    chk("rst_terr", terr, 1'b0);
    chk("rst_voted4", voted4, 8'h00);
    chk_clear("rst");

    // Unanimous replicas
    repeat (10) step(8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b1);
    chk("t1_voted", voted, 8'h5A);
    chk("t1_terr", terr, 1'b0);
    chk("t1_voted4", voted4, 8'h5A);
    chk_clear("t1");

    // A persistently wrong
    repeat (3) step(8'hFF, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("t2_fa_pre", fa, 1'b0);
    chk("t2_ca_pre", ca, 3);
    step(8'hFF, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("t2_fa", fa, 1'b1);
    chk("t2_ca", ca, 4);
    chk("t2_voted", voted, 8'h00);
    chk("t2_terr", terr, 1'b0);
    chk("t2_fa4", fa4, 1'b1);
    chk("t2_voted4", voted4, 8'h00);
    repeat (2) step(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("t2_fa_sticky", fa, 1'b1);
    chk("t2_ca_hold", ca, 4);
    chk("t2_fbc", {fb, fc}, 2'b00);

    // Degraded: B selected, B and C disagree
    step(8'h33, 8'h11, 8'h22, 1'b0, 1'b1);
    chk("t3_voted", voted, 8'h11);
    chk("t3_voted4", voted4, 8'h11);
    chk("t3_terr", terr, 1'b1);
    chk("t3_ca", ca, 4);
    chk("t3_cb", cb, 1);

    step(8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    chk_clear("clr1");
    chk("clr1_terr", terr, 1'b0);

    // No faults, no majority
    step(8'h00, 8'h01, 8'h02, 1'b0, 1'b1);
    chk("t4_voted", voted, 8'h00);
    chk("t4_terr", terr, 1'b1);
    chk("t4_cb", cb, 1);
    chk("t4_cc", cc, 1);
    chk("t4_ca", ca, 0);
    step(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("t4_rst_terr", terr, 1'b0);
    chk("t4_rst_voted", voted, 8'h00);

    // C wrong for 20 cycles: saturation on the 4-bit instance
    repeat (20) step(8'h00, 8'h00, 8'h0F, 1'b0, 1'b1);
    chk("t5_cc", cc, 20);
    chk("t5_cc4_sat", cc4, 4'hF);
    chk("t5_fc", fc, 1'b1);
    chk("t5_fc4", fc4, 1'b1);
    chk("t5_voted", voted, 8'h00);
    chk("t5_terr", terr, 1'b0);
    step(8'h00, 8'h00, 8'h0F, 1'b1, 1'b1);
    chk_clear("t5_clr");

    // Partial run, reset, then full run
    repeat (3) step(8'hFF, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("t6_ca", ca, 3);
    chk("t6_fa_pre", fa, 1'b0);
    step(8'hFF, 8'h00, 8'h00, 1'b0, 1'b0);
    chk_clear("t6_rst");
    chk("t6_rst_voted", voted, 8'h00);
    chk("t6_rst_terr", terr, 1'b0);
    step(8'hFF, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("t6_fa_1", fa, 1'b0);
    repeat (2) step(8'hFF, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("t6_fa_3", fa, 1'b0);
    step(8'hFF, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("t6_fa_4", fa, 1'b1);
    chk("t6_ca_4", ca, 4);

    // Reset wins over a simultaneous err_clr
    step(8'hFF, 8'h00, 8'h00, 1'b1, 1'b0);
    chk_clear("rstclr");

    // A and C fault on the same edge, then double-fault mode
    repeat (4) step(8'hFF, 8'hF0, 8'h00, 1'b0, 1'b1);
    chk("t7_faults", {fa, fb, fc}, 3'b101);
    chk("t7_terr", terr, 1'b1);
    chk("t7_voted", voted, 8'hF0);
    step(8'h11, 8'h22, 8'h33, 1'b0, 1'b1);
    chk("t7_voted2", voted, 8'h22);
    chk("t7_voted4", voted4, 8'h22);
    chk("t7_terr2", terr, 1'b1);
    step(8'h22, 8'h22, 8'h22, 1'b0, 1'b1);
    chk("t7_terr_hold", terr, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
